// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 constants, FSM encoding and encoding checks for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsu_state_t;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    logic sized;
    sized = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (store) return sized;
    return sized || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - request/response channel between the execute stage and the load/store unit
interface lsu_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_store, req_func3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_store, req_func3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_load_ext.sv
// rtl/lsu_load_ext.sv - funct3-driven sign/zero extension of low-aligned memory read data
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] dout
);

  always_comb begin
    dout = din;
    case (func3)
      F3_B:    dout = {{(XLEN-8){din[7]}}, din[7:0]};
      F3_H:    dout = {{(XLEN-16){din[15]}}, din[15:0]};
      F3_BU:   dout = {{(XLEN-8){1'b0}}, din[7:0]};
      F3_HU:   dout = {{(XLEN-16){1'b0}}, din[15:0]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - single-outstanding load/store controller in front of dmemory
// Optional LSU_MISALIGN_CHECK_EN routes misaligned halfword/word accesses to the error path.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_ctrl_if.slave         bus,
  output logic [2:0]        dm_func3,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [XLEN-1:0]   dm_wdata,
  output logic              dm_wen,
  input  logic [XLEN-1:0]   dm_rdata
);

  lsu_state_t      state_q, state_d;
  logic            store_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;
  logic [XLEN-1:0] ext_data;
  logic            bad;
  logic            req_ready;
  logic            rsp_valid;
  logic            wen;
  logic            accept;

`ifdef LSU_MISALIGN_CHECK_EN
  assign bad = !f3_legal(bus.req_store, bus.req_func3)
             || f3_misaligned(bus.req_func3, bus.req_addr[1:0]);
`else
  assign bad = !f3_legal(bus.req_store, bus.req_func3);
`endif

  assign accept = bus.req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // dm_wen is decoded straight from the state so an async reset drops it immediately.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    wen       = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) state_d = bad ? RESP : ACCESS;
      end
      ACCESS: begin
        wen     = store_q;
        state_d = store_q ? RESP : CAPTURE;
      end
      CAPTURE: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  lsu_load_ext #(.XLEN(XLEN)) u_ext (
    .func3 (f3_q),
    .din   (dm_rdata),
    .dout  (ext_data)
  );

  // Memory-side registers only move on a legal accept, so they hold across errors and idle time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q  <= 1'b0;
      f3_q     <= F3_W;
      dm_func3 <= F3_W;
      dm_addr  <= '0;
      dm_wdata <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        err_q   <= bad;
        rdata_q <= '0;
        if (!bad) begin
          store_q  <= bus.req_store;
          f3_q     <= bus.req_func3;
          dm_func3 <= {1'b0, bus.req_func3[1:0]};
          dm_addr  <= bus.req_addr;
          dm_wdata <= bus.req_wdata;
        end
      end
      if (state_q == CAPTURE) rdata_q <= ext_data;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign dm_wen        = wen;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with a byte-array reference model and dmemory stand-in
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.XLEN(32), .ADDR_W(32)) bus ();
  logic [2:0]  dm_func3;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_wen;

  lsu_ctrl #(.XLEN(32), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dm_func3 (dm_func3),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_wen   (dm_wen),
    .dm_rdata (dm_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wens;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] dmem [256];

  always @(posedge clk) cyc <= cyc + 1;

  // dmemory stand-in: byte addressed, registered read, low-aligned result
  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < size_of(f3); i++) v[8*i +: 8] = dmem[8'(a + 32'(i))];
    return v;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 8'(i * 7 + 3);
    end else if (dm_wen) begin
      for (int i = 0; i < size_of(dm_func3); i++) dmem[8'(dm_addr + 32'(i))] <= dm_wdata[8*i +: 8];
    end
    dm_rdata <= mem_rd(dm_addr, dm_func3);
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Reference model: architectural meaning of a request, in plain arithmetic over a byte array
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output exp_t e);
    int nb;
    longint v;
    bit legal, mis;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    nb = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    mis = (a % nb) != 0;
    e.rdata = 32'd0;
    e.wens = 0;
`ifdef LSU_MISALIGN_CHECK_EN
    e.err = !legal || mis;
`else
    e.err = !legal;
    if (mis) e.err = e.err;
`endif
    if (e.err) begin
      e.lat = 1;
    end else if (st) begin
      e.lat = 2;
      e.wens = 1;
      for (int i = 0; i < nb; i++) ref_mem[(a + i) % 256] = wd[8*i +: 8];
    end else begin
      e.lat = 3;
      v = 0;
      for (int i = 0; i < nb; i++) v += longint'(ref_mem[(a + i) % 256]) << (8 * i);
      if (f3 < 4 && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
      e.rdata = v[31:0];
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int hold);
    exp_t e;
    int t;
    model(st, f3, a, wd, e);
    exp_q.push_back(e);
    t = 0;
    while (!bus.req_ready && t < 50) begin @(posedge clk); #1; t++; end
    bus.req_valid = 1'b1;
    bus.req_store = st;
    bus.req_func3 = f3;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    t = 0;
    while (!bus.rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
    if (!bus.rsp_valid) begin
      n_vec++;
      n_bad++;
      $display("FAIL rsp_timeout got rsp_valid=0 want 1");
    end else begin
      repeat (hold) begin @(posedge clk); #1; end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
    end
  endtask

  // Monitor: pops the scoreboard whenever a new response appears
  logic        in_fl = 1'b0;
  logic        seen = 1'b0;
  int          t_acc = 0;
  int          wen_cnt = 0;
  logic [31:0] prev_rd;
  logic        prev_err;
  exp_t        me;

  initial begin
    forever begin
      @(negedge clk);
      check("dm_func3_bit2", {31'd0, dm_func3[2]}, 32'd0);
      if (!rst_n) begin
        in_fl = 1'b0;
        seen = 1'b0;
      end else begin
        if (in_fl) begin
          if (dm_wen) wen_cnt++;
        end else begin
          check("dm_wen_idle", {31'd0, dm_wen}, 32'd0);
        end
        if (in_fl && !bus.rsp_valid) check("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
        if (bus.rsp_valid) begin
          check("req_ready_resp", {31'd0, bus.req_ready}, 32'd0);
          if (!seen) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_bad++;
              $display("FAIL unexpected_rsp got rsp_valid=1 want 0");
            end else begin
              me = exp_q.pop_front();
              check("rsp_rdata", bus.rsp_rdata, me.rdata);
              check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, me.err});
              check("latency", 32'(cyc - t_acc), 32'(me.lat));
              check("dm_wen_pulses", 32'(wen_cnt), 32'(me.wens));
            end
            seen = 1'b1;
            prev_rd = bus.rsp_rdata;
            prev_err = bus.rsp_err;
          end else begin
            check("rsp_rdata_stable", bus.rsp_rdata, prev_rd);
            check("rsp_err_stable", {31'd0, bus.rsp_err}, {31'd0, prev_err});
          end
          if (bus.rsp_ready) begin
            in_fl = 1'b0;
            seen = 1'b0;
          end
        end
        if (bus.req_valid && bus.req_ready) begin
          in_fl = 1'b1;
          t_acc = cyc;
          wen_cnt = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
    bus.req_func3 = 3'd0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rst_dm_wen", {31'd0, dm_wen}, 32'd0);
    check("rst_dm_func3", {29'd0, dm_func3}, 32'd2);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_wdata", dm_wdata, 32'd0);
    mem_init = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1'b1, F3_W,  32'h10, 32'hDEADBEEF, 0);
    issue(1'b0, F3_W,  32'h10, 32'h0, 0);
    issue(1'b0, F3_B,  32'h10, 32'h0, 0);
    issue(1'b0, F3_BU, 32'h10, 32'h0, 0);
    issue(1'b0, F3_H,  32'h10, 32'h0, 0);
    issue(1'b0, F3_HU, 32'h10, 32'h0, 0);
    issue(1'b0, 3'b011, 32'h20, 32'h0, 0);
    issue(1'b1, 3'b100, 32'h20, 32'h12345678, 0);
    issue(1'b0, F3_W,  32'h10, 32'h0, 5);

    // Async reset during the ACCESS cycle of a store must suppress the write
    bus.req_valid = 1'b1;
    bus.req_store = 1'b1;
    bus.req_func3 = F3_W;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h11223344;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("wen_in_access", {31'd0, dm_wen}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("wen_killed_async", {31'd0, dm_wen}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("req_ready_after_rst", {31'd0, bus.req_ready}, 32'd1);
    issue(1'b0, F3_W, 32'h10, 32'h0, 0);
    issue(1'b0, F3_H, 32'h11, 32'h0, 0);

    for (int k = 0; k < 300; k++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)),
            $urandom, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
